// File: rtl/dual_input_debouncer.sv
// Two-channel input conditioner: 2-flop synchronizer, stability-count debounce,
// and registered rise/fall event pulses. Channel index 0 is A and index 1 is B.
module dual_input_debouncer #(
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_clean,
    output logic b_clean,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]                raw;
    logic [1:0]                s1;
    logic [1:0]                s2;
    logic [1:0]                clean;
    logic [1:0]                rise;
    logic [1:0]                fall;
    logic [1:0][CNT_WIDTH-1:0] cnt;

    assign raw = {b_raw, a_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            clean <= '0;
            rise  <= '0;
            fall  <= '0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int unsigned i = 0; i < 2; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                // Any return of s2 to the clean level drops the partial count.
                if (s2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    clean[i] <= s2[i];
                    cnt[i]   <= '0;
                    rise[i]  <= s2[i];
                    fall[i]  <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign a_clean = clean[0];
    assign b_clean = clean[1];
    assign a_rise  = rise[0];
    assign a_fall  = fall[0];
    assign b_rise  = rise[1];
    assign b_fall  = fall[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Bench for dual_input_debouncer: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance,
// checked every cycle against a sliding-window reference of the synchronized input.
module tb_dual_input_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b1, b_raw = 1'b1, a1_raw = 1'b1, b1_raw = 1'b1;
    logic a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;
    logic a1_clean, b1_clean, a1_rise, a1_fall, b1_rise, b1_fall;

    always #5 clk = ~clk;

    dual_input_debouncer #(.CNT_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
        .a_clean(a_clean), .b_clean(b_clean),
        .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall)
    );

    dual_input_debouncer #(.CNT_WIDTH(4), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .a_raw(a1_raw), .b_raw(b1_raw),
        .a_clean(a1_clean), .b_clean(b1_clean),
        .a_rise(a1_rise), .a_fall(a1_fall), .b_rise(b1_rise), .b_fall(b1_fall)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: channels 0..3 = dut4 A, dut4 B, dut1 A, dut1 B.
    // The clean level flips once the last D synchronized samples all disagree with it.
    int         dval[4] = '{4, 4, 1, 1};
    logic [1:0] raw_h[4];
    logic [7:0] seen_h[4];
    logic       clean_m[4];
    logic       rise_m[4];
    logic       fall_m[4];

    function automatic logic raw_of(input int ch);
        case (ch)
            0:       return a_raw;
            1:       return b_raw;
            2:       return a1_raw;
            default: return b1_raw;
        endcase
    endfunction

    function automatic logic [2:0] obs(input int ch);
        case (ch)
            0:       return {a_clean, a_rise, a_fall};
            1:       return {b_clean, b_rise, b_fall};
            2:       return {a1_clean, a1_rise, a1_fall};
            default: return {b1_clean, b1_rise, b1_fall};
        endcase
    endfunction

    task automatic set_raw(input int ch, input logic v);
        case (ch)
            0:       a_raw = v;
            1:       b_raw = v;
            2:       a1_raw = v;
            default: b1_raw = v;
        endcase
    endtask

    task automatic set_all(input logic v);
        for (int ch = 0; ch < 4; ch++) set_raw(ch, v);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            raw_h[ch]   = '0;
            seen_h[ch]  = '0;
            clean_m[ch] = 1'b0;
            rise_m[ch]  = 1'b0;
            fall_m[ch]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < 4; ch++) begin
            logic s2_now;
            logic all_diff;
            s2_now     = raw_h[ch][1];
            raw_h[ch]  = {raw_h[ch][0], raw_of(ch)};
            seen_h[ch] = {seen_h[ch][6:0], s2_now};
            rise_m[ch] = 1'b0;
            fall_m[ch] = 1'b0;
            all_diff   = 1'b1;
            for (int k = 0; k < dval[ch]; k++)
                if (seen_h[ch][k] == clean_m[ch]) all_diff = 1'b0;
            if (all_diff) begin
                clean_m[ch] = ~clean_m[ch];
                rise_m[ch]  = clean_m[ch];
                fall_m[ch]  = ~clean_m[ch];
            end
        end
    endtask

    task automatic compare();
        for (int ch = 0; ch < 4; ch++) begin
            logic [2:0] o;
            o = obs(ch);
            check($sformatf("ch%0d_clean", ch), int'(o[2]), int'(clean_m[ch]));
            check($sformatf("ch%0d_rise", ch), int'(o[1]), int'(rise_m[ch]));
            check($sformatf("ch%0d_fall", ch), int'(o[0]), int'(fall_m[ch]));
        end
        check("and_ab", int'(a_clean & b_clean), int'(clean_m[0] & clean_m[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs();
        for (int ch = 0; ch < 4; ch++) begin
            logic [2:0] o;
            o = obs(ch);
            check($sformatf("rst_ch%0d_clean", ch), int'(o[2]), 0);
            check($sformatf("rst_ch%0d_rise", ch), int'(o[1]), 0);
            check($sformatf("rst_ch%0d_fall", ch), int'(o[0]), 0);
        end
    endtask

    // Called just after a compare (posedge+1); asserts reset between edges.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts edges after reset release until each clean output first goes high.
    task automatic measure_latency(input string tag);
        int lat[4];
        for (int ch = 0; ch < 4; ch++) lat[ch] = -1;
        for (int e = 1; e <= 20; e++) begin
            logic [2:0] o;
            step();
            for (int ch = 0; ch < 4; ch++) begin
                o = obs(ch);
                if (lat[ch] < 0 && o[2]) lat[ch] = e;
            end
        end
        for (int ch = 0; ch < 4; ch++)
            check($sformatf("%s_lat_ch%0d", tag, ch), lat[ch], dval[ch] + 2);
    endtask

    initial begin
        int hold[4];

        // Reset with all raw inputs high, then release and time the clean rise.
        model_reset();
        #3;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        measure_latency("por");

        // A falls and rises again while B stays high.
        a_raw = 1'b0;
        run(10);
        a_raw = 1'b1;
        run(10);

        // Glitch rejection on A: 3-cycle high, bounce 1,0,1,1,0, then a real hold.
        a_raw = 1'b0;
        run(10);
        a_raw = 1'b1;
        run(3);
        a_raw = 1'b0;
        run(3);
        foreach (hold[i]) hold[i] = 0;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] pat;
            pat = 5'b10110;
            a_raw = pat[4-i];
            step();
        end
        a_raw = 1'b1;
        run(10);

        // Simultaneous A/B rise.
        set_all(1'b0);
        run(10);
        set_all(1'b1);
        run(10);

        // Reset during an in-progress count.
        set_all(1'b0);
        run(10);
        set_all(1'b1);
        run(4);
        pulse_reset();
        measure_latency("midrst");

        // Single-cycle pulse on the DEBOUNCE_CYCLES=1 instance.
        a1_raw = 1'b0;
        run(6);
        a1_raw = 1'b1;
        step();
        a1_raw = 1'b0;
        run(6);

        // Randomized hold lengths to mix glitches and genuine transitions.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (hold[ch] == 0) begin
                    set_raw(ch, 1'($urandom_range(0, 1)));
                    hold[ch] = int'($urandom_range(1, 8));
                end else begin
                    hold[ch]--;
                end
            end
            step();
            if (cyc == 1500) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
